// File: rtl/player_motion_ctrl.sv
// Player game-state FSM and signed-velocity jump physics, advanced by the two-phase game_tick.
// Optional landing jump buffer enabled by defining PLAYER_JUMP_BUFFER_EN.
module player_motion_ctrl #(
  parameter int unsigned POS_WIDTH             = 8,
  parameter int unsigned VEL_WIDTH             = 8,
  parameter int unsigned INITIAL_JUMP_VELOCITY = 12,
  parameter int unsigned GRAVITY               = 2,
  parameter int unsigned HOLD_GRAVITY          = 1,
  parameter int unsigned HOLD_TICKS            = 4,
  parameter int unsigned FASTDROP_VELOCITY     = 8,
  parameter int unsigned MAX_FALL              = 16,
  parameter int unsigned RESTART_HOLDOFF       = 8,
  parameter int unsigned BUFFER_TICKS          = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [1:0]           game_tick_i,
  input  logic                 button_up_i,
  input  logic                 button_down_i,
  input  logic                 crash_i,
  output logic [POS_WIDTH-1:0] player_position_o,
  output logic                 game_start_pulse_o,
  output logic                 game_over_pulse_o,
  output logic                 jump_pulse_o,
  output logic                 land_pulse_o,
  output logic                 jumping_o,
  output logic                 ducking_o,
  output logic                 game_over_o
);

  typedef enum logic [2:0] {StRestart, StRunning, StJumping, StDucking, StGameOver} state_e;

  localparam int unsigned SW    = ((POS_WIDTH > VEL_WIDTH) ? POS_WIDTH : VEL_WIDTH) + 2;
  localparam int unsigned HoldW = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam int unsigned OffW  = (RESTART_HOLDOFF < 1) ? 1 : $clog2(RESTART_HOLDOFF + 1);

  localparam logic signed [VEL_WIDTH-1:0] InitVel  = VEL_WIDTH'(INITIAL_JUMP_VELOCITY);
  localparam logic signed [VEL_WIDTH-1:0] VelZero  = '0;
  localparam logic signed [VEL_WIDTH:0]   GravX    = (VEL_WIDTH+1)'(GRAVITY);
  localparam logic signed [VEL_WIDTH:0]   HoldGrX  = (VEL_WIDTH+1)'(HOLD_GRAVITY);
  localparam logic signed [VEL_WIDTH:0]   FastX    = (VEL_WIDTH+1)'(FASTDROP_VELOCITY);
  localparam logic signed [VEL_WIDTH:0]   MaxFallX = (VEL_WIDTH+1)'(MAX_FALL);
  localparam logic signed [VEL_WIDTH:0]   NegFast  = -FastX;
  localparam logic signed [VEL_WIDTH:0]   NegMax   = -MaxFallX;
  localparam logic signed [SW-1:0]        SumZero  = '0;
  localparam logic signed [SW-1:0]        PosMax   = {{(SW-POS_WIDTH){1'b0}}, {POS_WIDTH{1'b1}}};
  localparam logic [HoldW-1:0]            HoldLoad = HoldW'(HOLD_TICKS);
  localparam logic [OffW-1:0]             OffLoad  = OffW'(RESTART_HOLDOFF);

  state_e                       state_q, state_d;
  logic [POS_WIDTH-1:0]         pos_q, pos_d;
  logic signed [VEL_WIDTH-1:0]  vel_q, vel_d;
  logic [HoldW-1:0]             hold_q, hold_d;
  logic [OffW-1:0]              off_q, off_d;
  // Set by a landing relaunch so the following tick0 applies no gravity.
  logic                         skip_q, skip_d;
  logic                         start_q, start_d, over_q, over_d, jump_q, jump_d, land_q, land_d;
  logic                         jumping_q, ducking_q, game_over_q;

  logic                         tick0, tick1;
  logic signed [VEL_WIDTH:0]    vel_x, vel_n;
  logic signed [SW-1:0]         pos_sx, vel_sx, sum;

`ifdef PLAYER_JUMP_BUFFER_EN
  localparam int unsigned BufW    = (BUFFER_TICKS < 1) ? 1 : $clog2(BUFFER_TICKS + 1);
  localparam logic [BufW-1:0] BufLoad = BufW'(BUFFER_TICKS);
  logic [BufW-1:0] buf_q, buf_d;
`endif

  assign tick0  = game_tick_i[0];
  assign tick1  = game_tick_i[1] & ~game_tick_i[0];
  assign vel_x  = {vel_q[VEL_WIDTH-1], vel_q};
  assign pos_sx = {{(SW-POS_WIDTH){1'b0}}, pos_q};
  assign vel_sx = {{(SW-VEL_WIDTH){vel_q[VEL_WIDTH-1]}}, vel_q};
  assign sum    = pos_sx + vel_sx;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    vel_d   = vel_q;
    hold_d  = hold_q;
    off_d   = off_q;
    skip_d  = skip_q;
    start_d = 1'b0;
    over_d  = 1'b0;
    jump_d  = 1'b0;
    land_d  = 1'b0;
    vel_n   = vel_x;
`ifdef PLAYER_JUMP_BUFFER_EN
    buf_d   = (state_q == StJumping) ? buf_q : '0;
`endif
    if (tick0) begin
      // Crash entry freezes position and velocity for the renderer.
      if (crash_i && (state_q == StRunning || state_q == StDucking || state_q == StJumping)) begin
        state_d = StGameOver;
        over_d  = 1'b1;
        off_d   = OffLoad;
        hold_d  = '0;
        skip_d  = 1'b0;
`ifdef PLAYER_JUMP_BUFFER_EN
        buf_d   = '0;
`endif
      end else begin
        unique case (state_q)
          StRestart, StRunning: begin
            if (button_up_i) begin
              state_d = StJumping;
              vel_d   = InitVel;
              hold_d  = HoldLoad;
              jump_d  = 1'b1;
              start_d = (state_q == StRestart);
            end else if (button_down_i && state_q == StRunning) begin
              state_d = StDucking;
            end
          end
          StDucking: begin
            if (!button_down_i) state_d = StRunning;
          end
          StJumping: begin
            if (skip_q) begin
              skip_d = 1'b0;
            end else begin
              if (button_down_i) begin
                vel_n  = NegFast;
                hold_d = '0;
              end else if (button_up_i && vel_q > VelZero && hold_q != '0) begin
                vel_n  = vel_x - HoldGrX;
                hold_d = hold_q - HoldW'(1);
              end else begin
                vel_n  = vel_x - GravX;
                hold_d = '0;
              end
              if (vel_n < NegMax) vel_n = NegMax;
              vel_d = vel_n[VEL_WIDTH-1:0];
`ifdef PLAYER_JUMP_BUFFER_EN
              if (button_up_i) buf_d = BufLoad;
              else if (buf_q != '0) buf_d = buf_q - BufW'(1);
`endif
            end
          end
          StGameOver: begin
            if (off_q == '0 && button_up_i) begin
              state_d = StRunning;
              pos_d   = '0;
              vel_d   = '0;
              start_d = 1'b1;
            end else if (off_q != '0) begin
              off_d = off_q - OffW'(1);
            end
          end
          default: ;
        endcase
      end
    end else if (tick1 && state_q == StJumping) begin
      if (sum <= SumZero) begin
        pos_d  = '0;
        vel_d  = '0;
        hold_d = '0;
        land_d = 1'b1;
`ifdef PLAYER_JUMP_BUFFER_EN
        if (buf_q != '0) begin
          vel_d  = InitVel;
          hold_d = HoldLoad;
          skip_d = 1'b1;
          jump_d = 1'b1;
          buf_d  = '0;
        end else begin
          state_d = button_down_i ? StDucking : StRunning;
        end
`else
        state_d = button_down_i ? StDucking : StRunning;
`endif
      end else if (sum > PosMax) begin
        pos_d = '1;
        vel_d = '0;
      end else begin
        pos_d = sum[POS_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StRestart;
      pos_q       <= '0;
      vel_q       <= '0;
      hold_q      <= '0;
      off_q       <= '0;
      skip_q      <= 1'b0;
      start_q     <= 1'b0;
      over_q      <= 1'b0;
      jump_q      <= 1'b0;
      land_q      <= 1'b0;
      jumping_q   <= 1'b0;
      ducking_q   <= 1'b0;
      game_over_q <= 1'b0;
`ifdef PLAYER_JUMP_BUFFER_EN
      buf_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      vel_q       <= vel_d;
      hold_q      <= hold_d;
      off_q       <= off_d;
      skip_q      <= skip_d;
      start_q     <= start_d;
      over_q      <= over_d;
      jump_q      <= jump_d;
      land_q      <= land_d;
      jumping_q   <= (state_d == StJumping);
      ducking_q   <= (state_d == StDucking);
      game_over_q <= (state_d == StGameOver);
`ifdef PLAYER_JUMP_BUFFER_EN
      buf_q       <= buf_d;
`endif
    end
  end

  assign player_position_o  = pos_q;
  assign game_start_pulse_o = start_q;
  assign game_over_pulse_o  = over_q;
  assign jump_pulse_o       = jump_q;
  assign land_pulse_o       = land_q;
  assign jumping_o          = jumping_q;
  assign ducking_o          = ducking_q;
  assign game_over_o        = game_over_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Self-checking bench for player_motion_ctrl: vector table for a full jump plus directed
// sequences for holdoff, held jump, fast drop, freeze, dual-tick, buffer and mid-jump reset.
module tb_player_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gt;
  logic       up, down, crash;
  logic [7:0] pos;
  logic       start_p, over_p, jump_p, land_p, jumping, ducking, gover;

  player_motion_ctrl dut (
    .clk_i              (clk),
    .reset_i            (rst),
    .game_tick_i        (gt),
    .button_up_i        (up),
    .button_down_i      (down),
    .crash_i            (crash),
    .player_position_o  (pos),
    .game_start_pulse_o (start_p),
    .game_over_pulse_o  (over_p),
    .jump_pulse_o       (jump_p),
    .land_pulse_o       (land_p),
    .jumping_o          (jumping),
    .ducking_o          (ducking),
    .game_over_o        (gover)
  );

  always #5 clk = ~clk;

  // Flag vector order: {start, over, jump, land, jumping, ducking, game_over}
  localparam logic [6:0] FNone       = 7'b0000000;
  localparam logic [6:0] FJmp        = 7'b0000100;
  localparam logic [6:0] FStartLaunch = 7'b1010100;
  localparam logic [6:0] FLaunch     = 7'b0010100;
  localparam logic [6:0] FLandRun    = 7'b0001000;
  localparam logic [6:0] FLandDuck   = 7'b0001010;
  localparam logic [6:0] FDuck       = 7'b0000010;
  localparam logic [6:0] FOverP      = 7'b0100001;
  localparam logic [6:0] FOver       = 7'b0000001;
  localparam logic [6:0] FStart      = 7'b1000000;
  localparam logic [6:0] FRelaunch   = 7'b0011100;

  typedef struct {
    logic [1:0] gt;
    logic       up;
    logic       down;
    logic       crash;
    logic [7:0] pos;
    logic [6:0] flg;
  } vec_t;

  vec_t tbl [64];
  int   n_vec;
  int   n_cmp;
  int   n_bad;
  int   hts [13];
  int   held [8];

  function automatic logic [6:0] flags();
    return {start_p, over_p, jump_p, land_p, jumping, ducking, gover};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] g, input logic u, input logic d, input logic c,
                     input logic [7:0] p, input logic [6:0] f);
    tbl[n_vec] = '{gt: g, up: u, down: d, crash: c, pos: p, flg: f};
    n_vec++;
  endtask

  task automatic cyc(input logic [1:0] g, input logic u, input logic d, input logic c);
    gt = g; up = u; down = d; crash = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; gt = 2'b00; up = 1'b0; down = 1'b0; crash = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit landed;
    n_cmp = 0; n_bad = 0; n_vec = 0;
    hts  = '{12, 22, 30, 36, 40, 42, 42, 40, 36, 30, 22, 12, 0};
    held = '{12, 23, 33, 42, 50, 56, 60, 62};

    do_reset();
    check("reset_pos", 32'(pos), 32'd0);
    check("reset_flags", 32'(flags()), 32'(FNone));

    // Start from RESTART, full unheld jump, duck, stand, crash
    add(2'b00, 1'b1, 1'b0, 1'b0, 8'd0, FNone);
    add(2'b10, 1'b1, 1'b0, 1'b0, 8'd0, FNone);
    add(2'b01, 1'b1, 1'b0, 1'b0, 8'd0, FStartLaunch);
    for (int k = 0; k < 13; k++) begin
      if (k > 0) add(2'b01, 1'b0, 1'b0, 1'b0, 8'(hts[k-1]), FJmp);
      add(2'b10, 1'b0, 1'b0, 1'b0, 8'(hts[k]), (k == 12) ? FLandRun : FJmp);
    end
    add(2'b01, 1'b0, 1'b1, 1'b0, 8'd0, FDuck);
    add(2'b01, 1'b0, 1'b0, 1'b0, 8'd0, FNone);
    add(2'b01, 1'b0, 1'b0, 1'b1, 8'd0, FOverP);

    for (int i = 0; i < n_vec; i++) begin
      cyc(tbl[i].gt, tbl[i].up, tbl[i].down, tbl[i].crash);
      check($sformatf("vec%0d_pos", i), 32'(pos), 32'(tbl[i].pos));
      check($sformatf("vec%0d_flags", i), 32'(flags()), 32'(tbl[i].flg));
    end

    // Restart holdoff: 8 ignored tick0s, then restart on the 9th
    for (int i = 0; i < 8; i++) begin
      cyc(2'b01, 1'b1, 1'b0, 1'b0);
      check($sformatf("holdoff%0d_flags", i), 32'(flags()), 32'(FOver));
    end
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    check("restart_flags", 32'(flags()), 32'(FStart));
    check("restart_pos", 32'(pos), 32'd0);

    // Held jump from RUNNING
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    check("held_launch_flags", 32'(flags()), 32'(FLaunch));
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc(2'b01, 1'b1, 1'b0, 1'b0);
      cyc(2'b10, 1'b1, 1'b0, 1'b0);
      check($sformatf("held_h%0d", k), 32'(pos), 32'(held[k]));
    end
    landed = 1'b0;
    for (int k = 0; k < 40 && !landed; k++) begin
      cyc(2'b01, 1'b1, 1'b0, 1'b0);
      cyc(2'b10, 1'b1, 1'b0, 1'b0);
      landed = land_p;
    end
    check("held_landed", 32'(landed), 32'd1);
    check("held_land_flags", 32'(flags()), 32'(FLandRun));

    // Fast drop at height 36 on the way up
    cyc(2'b01, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    check("fd_launch_flags", 32'(flags()), 32'(FLaunch));
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc(2'b01, 1'b0, 1'b0, 1'b0);
      cyc(2'b10, 1'b0, 1'b0, 1'b0);
    end
    check("fd_h36", 32'(pos), 32'd36);
    for (int k = 0; k < 4; k++) begin
      cyc(2'b01, 1'b0, 1'b1, 1'b0);
      cyc(2'b10, 1'b0, 1'b1, 1'b0);
      check($sformatf("fd_h%0d", k), 32'(pos), 32'(28 - 8 * k));
    end
    cyc(2'b01, 1'b0, 1'b1, 1'b0);
    cyc(2'b10, 1'b0, 1'b1, 1'b0);
    check("fd_land_flags", 32'(flags()), 32'(FLandDuck));
    check("fd_land_pos", 32'(pos), 32'd0);
    cyc(2'b01, 1'b0, 1'b0, 1'b0);
    check("fd_unduck_flags", 32'(flags()), 32'(FNone));

    // Mid-air crash freezes height
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    cyc(2'b10, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 1'b0, 1'b1);
    check("air_crash_flags", 32'(flags()), 32'(FOverP));
    cyc(2'b10, 1'b0, 1'b0, 1'b0);
    check("frozen_pos", 32'(pos), 32'd12);
    check("frozen_flags", 32'(flags()), 32'(FOver));
    for (int i = 0; i < 8; i++) cyc(2'b01, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    check("air_restart_pos", 32'(pos), 32'd0);
    check("air_restart_flags", 32'(flags()), 32'(FStart));

    // Both tick bits set: tick0 only
    cyc(2'b11, 1'b1, 1'b0, 1'b0);
    check("dual_launch_flags", 32'(flags()), 32'(FLaunch));
    cyc(2'b11, 1'b0, 1'b0, 1'b0);
    check("dual_no_pos", 32'(pos), 32'd0);
    cyc(2'b10, 1'b0, 1'b0, 1'b0);
    check("dual_pos10", 32'(pos), 32'd10);

    // Jump buffer: button_up pulsed two tick0s before landing
    do_reset();
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      if (k >= 2) cyc(2'b01, (k == 12), 1'b0, 1'b0);
      cyc(2'b10, 1'b0, 1'b0, 1'b0);
    end
    check("buf_land_pos", 32'(pos), 32'd0);
`ifdef PLAYER_JUMP_BUFFER_EN
    check("buf_land_flags", 32'(flags()), 32'(FRelaunch));
    cyc(2'b01, 1'b0, 1'b0, 1'b0);
    cyc(2'b10, 1'b0, 1'b0, 1'b0);
    check("buf_next_pos", 32'(pos), 32'd12);
    check("buf_next_flags", 32'(flags()), 32'(FJmp));
`else
    check("buf_land_flags", 32'(flags()), 32'(FLandRun));
    cyc(2'b01, 1'b0, 1'b0, 1'b0);
    cyc(2'b10, 1'b0, 1'b0, 1'b0);
    check("buf_next_pos", 32'(pos), 32'd0);
    check("buf_next_flags", 32'(flags()), 32'(FNone));
`endif

    // Reset mid-jump at height 30
    do_reset();
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc(2'b01, 1'b0, 1'b0, 1'b0);
      cyc(2'b10, 1'b0, 1'b0, 1'b0);
    end
    check("mid_h30", 32'(pos), 32'd30);
    rst = 1'b1;
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    check("mid_reset_pos", 32'(pos), 32'd0);
    check("mid_reset_flags", 32'(flags()), 32'(FNone));
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    check("mid_restart_flags", 32'(flags()), 32'(FStartLaunch));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
